// File: rtl/alu_arbiter_pkg.sv
// Shared ALU definitions: opcodes, cond-code bit positions, widths and the
// arbiter FSM state encoding.
package alu_arbiter_pkg;

  localparam int ALU_DW  = 32;
  localparam int ALU_CW  = 4;
  localparam int ALU_CCW = 6;

  localparam logic [ALU_CW-1:0] OP_ADD  = 4'b0001;
  localparam logic [ALU_CW-1:0] OP_SUB  = 4'b1001;
  localparam logic [ALU_CW-1:0] OP_AND  = 4'b0011;
  localparam logic [ALU_CW-1:0] OP_OR   = 4'b0100;
  localparam logic [ALU_CW-1:0] OP_SLL  = 4'b0101;
  localparam logic [ALU_CW-1:0] OP_SRL  = 4'b1101;
  localparam logic [ALU_CW-1:0] OP_LUI  = 4'b0111;
  localparam logic [ALU_CW-1:0] OP_SLT  = 4'b0010;
  localparam logic [ALU_CW-1:0] OP_SLTU = 4'b1010;

  // Cond-code vector is {eq, ne, lt, gt, zero, carry}, MSB first.
  localparam int CC_EQ    = 5;
  localparam int CC_NE    = 4;
  localparam int CC_LT    = 3;
  localparam int CC_GT    = 2;
  localparam int CC_ZERO  = 1;
  localparam int CC_CARRY = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way grant selection: round-robin against the last winner, or fixed
// priority to port 0 when RR is cleared.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_valid = valid0 | valid1;
    grant_id    = 1'b0;
    if (valid0 && valid1) begin
      grant_id = RR ? ~last_grant : 1'b0;
    end else if (valid1) begin
      grant_id = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: arbitrate, register operands, capture
// the result one cycle later and hold it on a single tagged response channel.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW  = ALU_DW,
  parameter int CW  = ALU_CW,
  parameter int CCW = ALU_CCW,
  parameter bit RR  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [CW-1:0]  req0_ctrl,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [CW-1:0]  req1_ctrl,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [CW-1:0]  alu_ctrl,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  input  logic [DW-1:0]  alu_res,
  input  logic [CCW-1:0] alu_cc,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic           resp_id,
  output logic [DW-1:0]  resp_data,
  output logic [CCW-1:0] resp_cc,
  output logic           busy
);

  state_e state;
  state_e state_next;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_id;
  logic   accept;

  rr_arb2 #(.RR(RR)) u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept     = (state == ST_IDLE) && grant_valid;
  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;
  assign resp_valid = (state == ST_RESP);
  assign busy       = (state != ST_IDLE);

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  // NOTE: datapath regs are reset too: ALU opcode 0 must yield result 0 and the response reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_cc    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant_id;
        resp_id    <= grant_id;
        alu_ctrl   <= grant_id ? req1_ctrl : req0_ctrl;
        alu_a      <= grant_id ? req1_a    : req0_a;
        alu_b      <= grant_id ? req1_b    : req0_b;
      end
      // Operands sat stable on the ALU for the whole EXEC cycle.
      if (state == ST_EXEC) begin
        resp_data <= alu_res;
        resp_cc   <= alu_cc;
      end
    end
  end

endmodule
